// File: rtl/motor_cmd_sched_pkg.sv
// Shared types and defaults for the motor command scheduler.
package motor_cmd_sched_pkg;

  localparam int N_AXES_DEF = 10;
  localparam int DIV_W_DEF  = 15;
  localparam int STEP_W_DEF = 15;
  localparam int ACK_TO_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_RUN      = 3'd3,
    ST_STOP     = 3'd4
  } axis_st_e;

endpackage

// File: rtl/motor_cmd_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the registered pointer.
module rr_arbiter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            best_off;
  int            off;

  // Lowest rotated distance from the pointer wins; index stays a loop constant.
  always_comb begin
    gnt      = '0;
    ptr_d    = ptr_q;
    best_off = N;
    off      = 0;
    for (int j = 0; j < N; j++) begin
      off = (j - int'(ptr_q) + N) % N;
      if (req[j] && off < best_off) best_off = off;
    end
    for (int j = 0; j < N; j++) begin
      off = (j - int'(ptr_q) + N) % N;
      if (req[j] && off == best_off) begin
        gnt[j] = 1'b1;
        ptr_d  = PW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/motor_cmd_sched.sv
// Per-axis shadow slot and load/run/stop sequencing toward the motor controllers.
module motor_cmd_sched
  import motor_cmd_sched_pkg::*;
#(
  parameter int N_AXES = N_AXES_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic                     CLK_SE_AR,
  input  logic                     RST_N,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_axis,
  input  logic [DIV_W-1:0]         cmd_divider,
  input  logic [STEP_W-1:0]        cmd_steps,
  input  logic                     cmd_dir,
  output logic [N_AXES*DIV_W-1:0]  mc_divider,
  output logic [N_AXES*STEP_W-1:0] mc_steps,
  output logic [N_AXES-1:0]        mc_dir,
  output logic [N_AXES-1:0]        mc_load,
  input  logic [N_AXES-1:0]        mc_active,
  output logic [N_AXES-1:0]        mc_stop,
  input  logic [N_AXES-1:0]        term_n,
  output logic [N_AXES-1:0]        pending,
  output logic [N_AXES-1:0]        limit_hit,
  output logic                     err_pulse
);

  localparam int CNT_W = $clog2(ACK_TO + 1);

  logic [N_AXES-1:0] sel, elig, gnt, tmo;
  logic              steps_zero;
  logic              err_q;

  assign steps_zero = (cmd_steps == '0);
  // sel is all-zero for an out-of-range axis, so it doubles as the range check.
  assign cmd_ready  = cmd_valid && (|sel) && (!(|(sel & pending)) || steps_zero);
  assign err_pulse  = err_q;

  rr_arbiter #(.N(N_AXES)) u_arb (
    .clk   (CLK_SE_AR),
    .rst_n (RST_N),
    .req   (elig),
    .gnt   (gnt)
  );

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    axis_st_e            st_q, st_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIV_W-1:0]    sh_div_q, div_q;
    logic [STEP_W-1:0]   sh_steps_q, steps_q;
    logic                sh_dir_q, dir_q;
    logic                pend_q, limit_q, load_q, stop_q;
    logic                acc, term_hit;

    assign sel[i]   = (cmd_axis == 4'(i));
    assign acc      = cmd_ready && sel[i];
    assign term_hit = !term_n[i] && (st_q == ST_WAIT_ACT || st_q == ST_RUN);
    assign elig[i]  = (st_q == ST_IDLE) && pend_q && !limit_q && !mc_active[i];
    assign tmo[i]   = (st_q == ST_WAIT_ACT) && !term_hit && !mc_active[i] &&
                      (cnt_q == CNT_W'(ACK_TO - 1));

    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_IDLE:     if (gnt[i]) st_d = ST_LOAD;
        ST_LOAD:     st_d = ST_WAIT_ACT;
        ST_WAIT_ACT: if (term_hit)          st_d = ST_STOP;
                     else if (mc_active[i]) st_d = ST_RUN;
                     else if (tmo[i])       st_d = ST_IDLE;
        ST_RUN:      if (term_hit)           st_d = ST_STOP;
                     else if (!mc_active[i]) st_d = ST_IDLE;
        ST_STOP:     if (!mc_active[i]) st_d = ST_IDLE;
        default:     st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge CLK_SE_AR or negedge RST_N) begin
      if (!RST_N) begin
        st_q       <= ST_IDLE;
        cnt_q      <= '0;
        sh_div_q   <= '0;
        sh_steps_q <= '0;
        sh_dir_q   <= 1'b0;
        div_q      <= '0;
        steps_q    <= '0;
        dir_q      <= 1'b0;
        pend_q     <= 1'b0;
        limit_q    <= 1'b0;
        load_q     <= 1'b0;
        stop_q     <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= (st_q == ST_WAIT_ACT) ? cnt_q + 1'b1 : '0;
        load_q <= gnt[i];
        if (gnt[i]) begin
          div_q   <= sh_div_q;
          steps_q <= sh_steps_q;
          dir_q   <= sh_dir_q;
        end
        // A fresh fill wins over the grant/limit clear in the same cycle.
        if (acc && !steps_zero) begin
          sh_div_q   <= cmd_divider;
          sh_steps_q <= cmd_steps;
          sh_dir_q   <= cmd_dir;
          pend_q     <= 1'b1;
        end else if (gnt[i] || term_hit) begin
          pend_q <= 1'b0;
        end
        if (term_hit)                limit_q <= 1'b1;
        else if (acc && steps_zero)  limit_q <= 1'b0;
        if (term_hit)                                  stop_q <= 1'b1;
        else if (st_q == ST_STOP && !mc_active[i])     stop_q <= 1'b0;
      end
    end

    assign mc_divider[i*DIV_W +: DIV_W]  = div_q;
    assign mc_steps[i*STEP_W +: STEP_W]  = steps_q;
    assign mc_dir[i]    = dir_q;
    assign mc_load[i]   = load_q;
    assign mc_stop[i]   = stop_q;
    assign pending[i]   = pend_q;
    assign limit_hit[i] = limit_q;
  end

  always_ff @(posedge CLK_SE_AR or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= (cmd_valid && !cmd_ready) || (|tmo);
  end

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched: vector table plus multi-cycle sequences.
module tb_motor_cmd_sched;

  localparam int NA = 10;
  localparam int DW = 15;
  localparam int SW = 15;
  localparam int AT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_axis;
  logic [DW-1:0]    cmd_divider;
  logic [SW-1:0]    cmd_steps;
  logic             cmd_dir;
  logic [NA*DW-1:0] mc_divider;
  logic [NA*SW-1:0] mc_steps;
  logic [NA-1:0]    mc_dir, mc_load, mc_active, mc_stop, term_n, pending, limit_hit;
  logic             err_pulse;

  int n_chk = 0;
  int n_fail = 0;

  motor_cmd_sched #(.N_AXES(NA), .DIV_W(DW), .STEP_W(SW), .ACK_TO(AT)) dut (
    .CLK_SE_AR   (clk),
    .RST_N       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_axis    (cmd_axis),
    .cmd_divider (cmd_divider),
    .cmd_steps   (cmd_steps),
    .cmd_dir     (cmd_dir),
    .mc_divider  (mc_divider),
    .mc_steps    (mc_steps),
    .mc_dir      (mc_dir),
    .mc_load     (mc_load),
    .mc_active   (mc_active),
    .mc_stop     (mc_stop),
    .term_n      (term_n),
    .pending     (pending),
    .limit_hit   (limit_hit),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [3:0]    ax;
    logic [SW-1:0] st;
    logic          rdy;
    logic          err;
    logic [NA-1:0] pend;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] steps_of(input int a);
    return mc_steps[a*SW +: SW];
  endfunction

  function automatic logic [DW-1:0] div_of(input int a);
    return mc_divider[a*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    mc_active = '0;
    term_n = '1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] ax, input logic [DW-1:0] dv, input logic [SW-1:0] st,
                      input logic d, input logic exp_rdy, input string nm);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_axis = ax;
    cmd_divider = dv;
    cmd_steps = st;
    cmd_dir = d;
    #1 chk(nm, cmd_ready, exp_rdy);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_load"}, mc_load, 0);
    chk({nm, "_stop"}, mc_stop, 0);
    chk({nm, "_pend"}, pending, 0);
    chk({nm, "_lim"}, limit_hit, 0);
    chk({nm, "_err"}, err_pulse, 0);
    chk({nm, "_mc"}, {|mc_divider, |mc_steps, |mc_dir}, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_axis = '0; cmd_divider = '0;
    cmd_steps = '0; cmd_dir = 1'b0; mc_active = '0; term_n = '1;

    tbl[0] = '{1'b0, 4'd3,  15'd5,      1'b0, 1'b0, 10'h000};
    tbl[1] = '{1'b1, 4'd12, 15'd5,      1'b0, 1'b1, 10'h000};
    tbl[2] = '{1'b1, 4'd10, 15'd0,      1'b0, 1'b1, 10'h000};
    tbl[3] = '{1'b1, 4'd9,  15'd7,      1'b1, 1'b0, 10'h200};
    tbl[4] = '{1'b1, 4'd9,  15'd3,      1'b0, 1'b1, 10'h200};
    tbl[5] = '{1'b1, 4'd9,  15'd0,      1'b1, 1'b0, 10'h200};
    tbl[6] = '{1'b1, 4'd0,  15'd1,      1'b1, 1'b0, 10'h201};
    tbl[7] = '{1'b0, 4'd0,  15'd1,      1'b0, 1'b0, 10'h201};
    tbl[8] = '{1'b1, 4'd15, 15'd0,      1'b0, 1'b1, 10'h201};
    tbl[9] = '{1'b1, 4'd4,  15'h7FFF,   1'b1, 1'b0, 10'h211};

    // Reset state and handshake table; all controllers busy so nothing issues.
    do_reset();
    #1 chk_all_zero("reset");
    mc_active = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = tbl[i].v;
      cmd_axis = tbl[i].ax;
      cmd_steps = tbl[i].st;
      cmd_divider = DW'(i);
      cmd_dir = 1'b0;
      #1 chk($sformatf("row%0d_ready", i), cmd_ready, tbl[i].rdy);
      tick();
      chk($sformatf("row%0d_err", i), err_pulse, tbl[i].err);
      chk($sformatf("row%0d_pend", i), pending, tbl[i].pend);
      chk($sformatf("row%0d_load", i), mc_load, 0);
    end
    cmd_valid = 1'b0;
    @(negedge clk) mc_active = '0;
    tick(); chk("drain_g0", mc_load, 10'h001); chk("drain_s0", steps_of(0), 1);
    tick(); chk("drain_g4", mc_load, 10'h010); chk("drain_s4", steps_of(4), 15'h7FFF);
    tick(); chk("drain_g9", mc_load, 10'h200); chk("drain_s9", steps_of(9), 7);
    chk("drain_d9", div_of(9), 3); chk("drain_pend", pending, 0);
    tick(); chk("drain_idle", mc_load, 0);

    // Basic load latency, then ack timeout.
    do_reset();
    send(4'd3, 15'h00FF, 15'd6, 1'b1, 1'b1, "a3_ready");
    chk("a3_pend1", pending, 10'h008); chk("a3_noload", mc_load, 0);
    tick();
    chk("a3_load", mc_load, 10'h008); chk("a3_steps", steps_of(3), 6);
    chk("a3_div", div_of(3), 15'h00FF); chk("a3_dir", mc_dir[3], 1); chk("a3_pend0", pending, 0);
    tick(); chk("a3_single", mc_load, 0);
    repeat (AT - 1) tick();
    chk("to_early", err_pulse, 0);
    tick(); chk("to_pulse", err_pulse, 1);
    tick(); chk("to_once", err_pulse, 0);
    send(4'd3, 15'd1, 15'd2, 1'b0, 1'b1, "to_reissue_rdy");
    tick(); chk("to_idle_reload", mc_load, 10'h008);

    // Second command while the slot is full is dropped.
    do_reset();
    mc_active = 10'h010;
    send(4'd4, 15'd0, 15'h11, 1'b0, 1'b1, "dup_first");
    send(4'd4, 15'd0, 15'h22, 1'b0, 1'b0, "dup_second");
    chk("dup_err", err_pulse, 1); chk("dup_pend", pending, 10'h010);
    @(negedge clk) mc_active = '0;
    tick();
    chk("dup_err_once", err_pulse, 0); chk("dup_load", mc_load, 10'h010);
    chk("dup_steps", steps_of(4), 15'h11);

    // Limit switch in RUN with a shadow pending.
    do_reset();
    send(4'd7, 15'd0, 15'd9, 1'b0, 1'b1, "lim_first");
    tick(); chk("lim_load", mc_load, 10'h080);
    @(negedge clk) mc_active = 10'h080;
    tick(); tick();
    send(4'd7, 15'd0, 15'd3, 1'b0, 1'b1, "lim_shadow");
    chk("lim_pend", pending, 10'h080);
    @(negedge clk) term_n[7] = 1'b0;
    tick();
    chk("lim_stop", mc_stop, 10'h080); chk("lim_hit", limit_hit, 10'h080); chk("lim_flush", pending, 0);
    tick(); chk("lim_stop_hold", mc_stop, 10'h080);
    @(negedge clk) begin term_n = '1; mc_active = '0; end
    tick(); chk("lim_stop_drop", mc_stop, 0); chk("lim_sticky", limit_hit, 10'h080);
    send(4'd7, 15'd0, 15'd5, 1'b1, 1'b1, "lim_acc_blocked");
    tick(); chk("lim_no_issue", mc_load, 0); chk("lim_pend2", pending, 10'h080);
    send(4'd7, 15'd0, 15'd0, 1'b0, 1'b1, "lim_clr_rdy");
    chk("lim_clr", limit_hit, 0); chk("lim_clr_noload", mc_load, 0);
    tick(); chk("lim_issue", mc_load, 10'h080); chk("lim_steps", steps_of(7), 5);

    // Round-robin ordering from pointer 6.
    do_reset();
    send(4'd5, 15'd0, 15'd1, 1'b0, 1'b1, "rr_prime");
    tick(); chk("rr_prime_load", mc_load, 10'h020);
    @(negedge clk) mc_active = 10'h224;
    send(4'd2, 15'd0, 15'd2, 1'b0, 1'b1, "rr_c2");
    send(4'd5, 15'd0, 15'd5, 1'b0, 1'b1, "rr_c5");
    send(4'd9, 15'd0, 15'd9, 1'b0, 1'b1, "rr_c9");
    chk("rr_pend", pending, 10'h224);
    tick(); chk("rr_hold", mc_load, 0);
    @(negedge clk) mc_active = '0;
    tick(); chk("rr_g9", mc_load, 10'h200); chk("rr_s9", steps_of(9), 9);
    tick(); chk("rr_g2", mc_load, 10'h004); chk("rr_s2", steps_of(2), 2);
    tick(); chk("rr_g5", mc_load, 10'h020); chk("rr_s5", steps_of(5), 5);

    // Bad axis, then asynchronous reset while stopping axis 0.
    do_reset();
    send(4'd12, 15'd0, 15'd1, 1'b0, 1'b0, "bad_axis_rdy");
    chk("bad_axis_err", err_pulse, 1);
    send(4'd0, 15'd0, 15'd2, 1'b0, 1'b1, "ar_cmd");
    tick(); chk("ar_load", mc_load, 10'h001);
    @(negedge clk) mc_active = 10'h001;
    tick(); tick();
    @(negedge clk) term_n[0] = 1'b0;
    tick(); chk("ar_stop", mc_stop, 10'h001);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_all_zero("ar_in_reset");
    term_n = '1; mc_active = '0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk_all_zero("ar_after");
    mc_active = 10'h009;
    send(4'd3, 15'd0, 15'd3, 1'b0, 1'b1, "ptr_c3");
    send(4'd0, 15'd0, 15'd4, 1'b0, 1'b1, "ptr_c0");
    @(negedge clk) mc_active = '0;
    tick(); chk("ptr_first0", mc_load, 10'h001);
    tick(); chk("ptr_then3", mc_load, 10'h008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motor_cmd_sched.md
MOTOR_CMD_SCHED -- requirements
Module: motor_cmd_sched

Interface
REQ-001 SHALL have parameter N_AXES, default 10: number of motor channels.
REQ-002 SHALL have parameter DIV_W, default 15: divider field width.
REQ-003 SHALL have parameter STEP_W, default 15: step-count field width.
REQ-004 SHALL have parameter ACK_TO, default 15: maximum cycles to wait for motor active after a load.
REQ-005 SHALL have port CLK_SE_AR, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit: a decoded command is offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: the command is accepted this cycle.
REQ-009 SHALL have port cmd_axis, input, 4 bits: target axis.
REQ-010 SHALL have ports cmd_divider (input, DIV_W bits) and cmd_steps (input, STEP_W bits): speed divider and step count.
REQ-011 SHALL have port cmd_dir, input, 1 bit: direction.
REQ-012 SHALL have ports mc_divider (output, N_AXES*DIV_W bits), mc_steps (output, N_AXES*STEP_W bits) and mc_dir (output, N_AXES bits): per-axis registered parameters driven to the motor controllers.
REQ-013 SHALL have port mc_load, output, N_AXES bits: one-hot, single-cycle load strobe.
REQ-014 SHALL have port mc_active, input, N_AXES bits: motor controller busy.
REQ-015 SHALL have port mc_stop, output, N_AXES bits: abort request to the motor controller.
REQ-016 SHALL have port term_n, input, N_AXES bits: limit switches, active-low, already synchronised.
REQ-017 SHALL have ports pending (output, N_AXES bits) and limit_hit (output, N_AXES bits): shadow slot full, and sticky limit flag.
REQ-018 SHALL have port err_pulse, output, 1 bit: single-cycle pulse on a rejected command.

Function
REQ-019 Each axis SHALL hold one shadow entry (divider, steps, dir) and a per-axis state machine with states IDLE, LOAD, WAIT_ACT, RUN and STOP.
REQ-020 cmd_ready SHALL be combinational and equal cmd_valid && cmd_axis < N_AXES && (!pending[cmd_axis] || cmd_steps == 0).
REQ-021 On cmd_valid with cmd_axis >= N_AXES, err_pulse SHALL be 1 for one cycle.
REQ-022 On cmd_valid with pending[cmd_axis] set and cmd_steps != 0, err_pulse SHALL be 1 for one cycle, the command SHALL be dropped and state SHALL be unchanged.
REQ-023 An accepted command with cmd_steps == 0 SHALL clear limit_hit[axis] and SHALL NOT fill the shadow.
REQ-024 An accepted command with cmd_steps != 0 SHALL fill the shadow and set pending[axis] the next cycle.
REQ-025 An accepted command with cmd_steps != 0 SHALL be accepted when limit_hit is set, but SHALL NOT be issued while limit_hit is set.
REQ-026 Arbitration: in a cycle, an axis is eligible when it is IDLE, pending=1, limit_hit=0 and mc_active=0.
REQ-027 A round-robin pointer SHALL grant at most one eligible axis per cycle, searching from the pointer upward with wrap at N_AXES-1 to 0.
REQ-028 After a grant, the pointer SHALL move to grant+1 (mod N_AXES).
REQ-029 A granted axis SHALL go to LOAD, where mc_* registers take the shadow value, mc_load[i] pulses for exactly 1 cycle, and pending[i] clears.
REQ-030 The latency from the cmd accept edge to the mc_load pulse SHALL be 2 cycles when uncontended.
REQ-031 A new command to the same axis SHALL be acceptable in the same cycle pending clears; accept has priority over the clear.
REQ-032 Transition LOAD to WAIT_ACT SHALL be unconditional.
REQ-033 In WAIT_ACT, mc_active=1 SHALL move the axis to RUN; if mc_active stays 0 for ACK_TO cycles, the axis SHALL move to IDLE and pulse err_pulse.
REQ-034 In RUN, falling mc_active SHALL move the axis to IDLE.
REQ-035 When term_n[i]=0 in WAIT_ACT or RUN, the axis SHALL set limit_hit[i], clear pending[i] (flush the shadow), go to STOP and hold mc_stop[i]=1.
REQ-036 The axis SHALL leave STOP for IDLE when mc_active[i]=0, deasserting mc_stop on the same edge.
REQ-037 When term_n[i]=0 in IDLE, limit_hit SHALL NOT be set.
REQ-038 When err_pulse has multiple sources in the same cycle, they SHALL OR into a single pulse.

Reset
REQ-039 RST_N=0 SHALL asynchronously set all states to IDLE, set mc_divider, mc_steps, mc_dir, mc_load, mc_stop, pending, limit_hit, err_pulse and the pointer to 0, and clear the timeout counters.
REQ-040 When reset is asserted mid-RUN, mc_stop SHALL be 0 during reset, and the motor controller's own reset covers the abort.
REQ-041 Deassertion of RST_N SHALL be synchronised externally; the first legal command is on the first edge after release.

Structure
REQ-042 A shared package SHALL hold the state enum (IDLE/LOAD/WAIT_ACT/RUN/STOP), default DIV_W/STEP_W/N_AXES and the ACK_TO constant.
REQ-043 Sub-module rr_arbiter (N-bit request, one-hot grant, registered pointer) SHALL be instantiated once.
REQ-044 Per-axis logic SHALL be a generate loop in motor_cmd_sched.

Verification
REQ-045 Scenario: a cmd on axis 3 with divider 0x00FF, steps 6, dir 1 -> mc_load[3] at accept+2, mc_steps[3]=6, mc_dir[3]=1, pending[3] 1 then 0.
REQ-046 Scenario: axes 2, 5 and 9 pending and all idle with the pointer at 6 -> grants in the order 9, 2, 5 on consecutive cycles.
REQ-047 Scenario: a second cmd to axis 4 while pending[4]=1 -> cmd_ready=0, err_pulse for 1 cycle, and mc_steps[4] keeps the first value.
REQ-048 Scenario: term_n[7]=0 while axis 7 is in RUN with a shadow pending -> mc_stop[7]=1, limit_hit[7]=1, pending[7]=0; mc_stop drops after mc_active[7] falls; a cmd with steps 0 clears limit_hit[7].
REQ-049 Scenario: mc_active is never asserted after a load -> err_pulse exactly ACK_TO cycles after WAIT_ACT entry, and the axis is IDLE.
REQ-050 Scenario: a cmd_axis of 12, then RST_N pulsed low mid-RUN on axis 0 -> err_pulse; after reset, all outputs are 0 and the pointer is 0.
